booth_multiplier_seq: RTL and testbench



---
 rtl/booth_multiplier_seq.sv | 69 ++++++
 tb/tb_booth_multiplier_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: sequential radix-2 Booth multiplier, one step per clock, start/busy/done handshake
module booth_multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic             in_clk,
  input  logic             in_reset_n,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic signed [WIDTH:0] r_a, r_m, w_sum, w_a;
  logic [WIDTH-1:0] r_q, w_q, r_hi, r_lo;
  logic r_qm1, w_qm1, w_last;
  logic [CW-1:0] r_count;
  // A is one bit wider than the operands so that subtracting M = -2^(WIDTH-1) cannot overflow
  always_comb begin
    w_sum = ({r_q[0], r_qm1} == 2'b01) ? r_a + r_m :
            ({r_q[0], r_qm1} == 2'b10) ? r_a - r_m : r_a;
    {w_a, w_q, w_qm1} = {w_sum[WIDTH], w_sum, r_q};
    w_last = r_count == CW'(WIDTH - 1);
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_start ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_start) begin
        r_a     <= '0;
        r_m     <= {in_x[WIDTH-1], in_x};
        r_q     <= in_y;
        r_qm1   <= 1'b0;
        r_count <= '0;
      end else if (r_state == RUN) begin
        r_a     <= w_a;
        r_q     <= w_q;
        r_qm1   <= w_qm1;
        r_count <= r_count + 1'b1;
        if (w_last) begin
          r_hi <= w_a[WIDTH-1:0];
          r_lo <= w_q;
        end
      end
    end
  end
  assign out_busy = r_state != IDLE;
  assign out_done = r_state == DONE;
  assign out_hi   = r_hi;
  assign out_lo   = r_lo;
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb_booth_multiplier_seq: directed scoreboard bench for the sequential Booth multiplier
module tb_booth_multiplier_seq;
  logic in_clk = 1'b0, in_reset_n, in_start;
  logic [31:0] in_x, in_y, out_hi, out_lo;
  logic out_busy, out_done;
  logic [63:0] sb[$];
  int tests = 0, fails = 0;

  booth_multiplier_seq #(.WIDTH(32)) dut (
    .in_clk(in_clk), .in_reset_n(in_reset_n), .in_start(in_start),
    .in_x(in_x), .in_y(in_y), .out_busy(out_busy), .out_done(out_done),
    .out_hi(out_hi), .out_lo(out_lo)
  );

  always #5 in_clk = ~in_clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    pa = $signed(a);
    pb = $signed(b);
    return pa * pb;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge, ends at the negedge of the first IDLE cycle after DONE.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit poke, input bit abort);
    logic [63:0] prev, exp;
    int n;
    bit held;
    prev = {out_hi, out_lo};
    held = 1'b1;
    in_x = x;
    in_y = y;
    in_start = 1'b1;
    sb.push_back(model(x, y));
    @(posedge in_clk);
    #1 chk("busy_after_accept", out_busy, 1);
    @(negedge in_clk);
    in_start = 1'b0;
    in_x = $urandom;
    in_y = $urandom;
    n = 0;
    while (n < 40 && out_done !== 1'b1) begin
      @(negedge in_clk);
      n++;
      if (out_done !== 1'b1 && {out_hi, out_lo} !== prev) held = 1'b0;
      if (poke && n == 10) begin
        in_start = 1'b1;
        in_x = $urandom;
        in_y = $urandom;
      end
      if (poke && n == 12) in_start = 1'b0;
      if (abort && n == 10) begin
        in_reset_n = 1'b0;
        #1;
        chk("abort_busy", out_busy, 0);
        chk("abort_done", out_done, 0);
        chk("abort_hi", out_hi, 0);
        chk("abort_lo", out_lo, 0);
        exp = sb.pop_front();
        return;
      end
    end
    exp = sb.pop_front();
    chk("latency", n, 32);
    chk("product", {out_hi, out_lo}, exp);
    chk("prev_held", held, 1);
    @(negedge in_clk);
    chk("done_single_pulse", out_done, 0);
    chk("idle_after_done", out_busy, 0);
  endtask

  initial begin
    in_reset_n = 1'b0;
    in_start = 1'b0;
    in_x = '0;
    in_y = '0;
    repeat (2) @(negedge in_clk);
    chk("rst_busy", out_busy, 0);
    chk("rst_done", out_done, 0);
    chk("rst_hi", out_hi, 0);
    chk("rst_lo", out_lo, 0);
    in_reset_n = 1'b1;
    repeat (5) @(negedge in_clk);
    chk("idle_busy", out_busy, 0);
    chk("idle_done", out_done, 0);
    chk("idle_prod", {out_hi, out_lo}, 0);
    run_op(32'd12, 32'd7, 0, 0);
    run_op(32'hFFFFFFFB, 32'd3, 0, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_op(32'h80000000, 32'h80000000, 0, 0);
    run_op(32'h7FFFFFFF, 32'h80000000, 0, 0);
    run_op(32'd1234, -32'sd567, 1, 0);
    @(negedge in_clk);
    chk("no_queued_start", out_busy, 0);
    run_op(32'h80000000, 32'h7FFFFFFF, 0, 0);
    run_op(32'h0001_2345, 32'hFFFE_0001, 0, 0);
    run_op($urandom, $urandom, 0, 0);
    run_op(32'hDEADBEEF, 32'h13579BDF, 0, 1);
    @(negedge in_clk);
    chk("in_reset_prod", {out_hi, out_lo}, 0);
    in_reset_n = 1'b1;
    repeat (3) @(negedge in_clk);
    chk("post_abort_done", out_done, 0);
    chk("post_abort_busy", out_busy, 0);
    run_op(32'hFFFF8000, 32'h00007FFF, 0, 0);
    run_op(32'd0, 32'h80000000, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
